// File: rtl/wave_pkg.sv
// wave_pkg: shared constants and state encodings for the wave capture path.
// Revision: 1.0
`default_nettype none

package wave_pkg;

    localparam int SAMPLE_W         = 16;
    localparam int DISP_W           = 8;
    localparam int DEF_SAMPLES_LOG2 = 8;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    // Offset-binary display byte: top byte with the sign bit inverted.
    function automatic logic [DISP_W-1:0] to_disp(input logic [SAMPLE_W-1:0] s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-DISP_W]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_trigger_detect.sv
// wave_trigger_detect: rising zero-crossing detector; hysteresis when WAVE_CAPTURE_HYST_EN is defined.
// Revision: 1.0
`default_nettype none

module wave_trigger_detect
    import wave_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] HYST = 16'd256
) (
    input  logic [SAMPLE_W-1:0] prev,
    input  logic [SAMPLE_W-1:0] cur,
    output logic                trigger
);

    // Only the sign of the current sample matters for the crossing.
    logic w_unused_cur;
    assign w_unused_cur = ^cur[SAMPLE_W-2:0];

`ifdef WAVE_CAPTURE_HYST_EN
    assign trigger = ($signed(prev) <= -$signed(HYST)) && !cur[SAMPLE_W-1];
`else
    logic w_unused_hyst;
    assign w_unused_hyst = ^{prev[SAMPLE_W-2:0], HYST};
    assign trigger = prev[SAMPLE_W-1] && !cur[SAMPLE_W-1];
`endif

endmodule

`default_nettype wire

// File: rtl/wave_capture.sv
// wave_capture: triggered capture of one screen of samples into the back half of the display RAM.
// Optional macro WAVE_CAPTURE_HYST_EN enables trigger hysteresis. Revision: 1.0
`default_nettype none

module wave_capture
    import wave_pkg::*;
#(
    parameter int                  SAMPLES_LOG2 = DEF_SAMPLES_LOG2,
    parameter logic [SAMPLE_W-1:0] HYST         = 16'd256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample_ready,
    input  logic [SAMPLE_W-1:0]   new_sample_in,
    input  logic                  wave_display_idle,
    output logic [SAMPLES_LOG2:0] write_address,
    output logic                  write_enable,
    output logic [DISP_W-1:0]     write_sample,
    output logic                  read_index
);

    logic [1:0]              state_q,  state_d;
    logic [SAMPLES_LOG2-1:0] index_q,  index_d;
    logic [SAMPLE_W-1:0]     prev_q,   prev_d;
    logic                    rdidx_q,  rdidx_d;
    logic                    we_q,     we_d;
    logic [SAMPLES_LOG2:0]   waddr_q,  waddr_d;
    logic [DISP_W-1:0]       wdata_q,  wdata_d;
    logic                    w_trigger;

    wave_trigger_detect #(
        .HYST    (HYST)
    ) u_trig (
        .prev    (prev_q),
        .cur     (new_sample_in),
        .trigger (w_trigger)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        rdidx_d = rdidx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        prev_d  = new_sample_ready ? new_sample_in : prev_q;

        case (state_q)
            ST_ARMED: begin
                if (new_sample_ready && w_trigger) begin
                    we_d    = 1'b1;
                    waddr_d = {~rdidx_q, {SAMPLES_LOG2{1'b0}}};
                    wdata_d = to_disp(new_sample_in);
                    index_d = {{(SAMPLES_LOG2-1){1'b0}}, 1'b1};
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    we_d    = 1'b1;
                    waddr_d = {~rdidx_q, index_q};
                    wdata_d = to_disp(new_sample_in);
                    index_d = index_q + 1'b1;
                    if (index_q == {SAMPLES_LOG2{1'b1}}) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Flip only while the display is blanked so a frame never tears.
                if (wave_display_idle) begin
                    rdidx_d = ~rdidx_q;
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARMED;
            index_q <= '0;
            prev_q  <= '0;
            rdidx_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            prev_q  <= prev_d;
            rdidx_q <= rdidx_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign write_address = waddr_q;
    assign write_enable  = we_q;
    assign write_sample  = wdata_q;
    assign read_index    = rdidx_q;

endmodule

`default_nettype wire

// File: doc/wave_capture.md
# wave_capture

Capture controller that sequences writes of incoming audio samples into the double-buffered wave display RAM. It arms on a rising zero crossing, writes one full screen of 256 samples into the half of the RAM not being displayed, then waits for the display to go idle (vertical blank) and flips `read_index`. It sits between the codec sample stream and `wave_display_top`, whose RAM it owns on the write side.

## Interface
- `SAMPLES_LOG2`, 8: log2 of samples per capture; RAM half depth.
- `HYST`, 16'd256: trigger hysteresis magnitude; used only when `WAVE_CAPTURE_HYST_EN` is defined.
- `clk` input 1: single system clock; all logic rising-edge.
- `reset` input 1: synchronous, active-high.
- `new_sample_ready` input 1: one-cycle strobe; `new_sample_in` valid this cycle.
- `new_sample_in` input 16: signed two's-complement audio sample.
- `wave_display_idle` input 1: high while the display is not scanning (vsync blank).
- `write_address` output SAMPLES_LOG2+1: `{~read_index, index}` RAM write address.
- `write_enable` output 1: RAM write strobe, one cycle per sample.
- `write_sample` output 8: display sample, `new_sample_in[15:8]` with MSB inverted (offset binary).
- `read_index` output 1: RAM half the display reads; the other half is written.

## Operation
- States: ARMED, ACTIVE, WAIT. Reset state ARMED.
- `prev` register holds the last accepted sample; updated on every `new_sample_ready` in every state.
- ARMED: on `new_sample_ready`, trigger if `prev[15]==1` and `new_sample_in[15]==0`. On trigger: write the triggering sample at index 0, set index to 1, go ACTIVE. No trigger: no write, stay.
- ACTIVE: each `new_sample_ready` writes sample at current index, index increments. Write at index 2^SAMPLES_LOG2-1 goes to WAIT; index wraps to 0.
- WAIT: no writes. When `wave_display_idle==1`, toggle `read_index`, go ARMED. Samples arriving in WAIT only update `prev`.
- Write address half is `~read_index` sampled at the write; `read_index` never changes in ARMED/ACTIVE, so one capture never straddles halves.
- Conversion: `write_sample = {~new_sample_in[15], new_sample_in[14:8]}`; no rounding, lower byte dropped.

## Timing
- Reset values: `write_enable=0`, `write_address=0`, `write_sample=0`, `read_index=0`, index 0, `prev=0`, state ARMED.
- `reset` mid-capture: next cycle is ARMED with all reset values; partial buffer abandoned, `read_index` returns to 0.
- Write latency: `new_sample_ready` at cycle N -> `write_enable` high for exactly cycle N+1 with registered `write_address`/`write_sample`.
- `new_sample_ready` strobes may be back-to-back (every cycle); each produces one write in ACTIVE.
- WAIT exit: `wave_display_idle` sampled high at cycle N -> `read_index` toggled and state ARMED at N+1. Idle already high on entry -> toggle the cycle after entry.
- The final ACTIVE write and WAIT entry share the same edge; a strobe in the first WAIT cycle is not written.
- Trigger in ARMED uses `prev` from before the current sample; the first sample after reset compares against `prev=0` and cannot trigger.

## Configuration
- `WAVE_CAPTURE_HYST_EN` defined: trigger requires `$signed(prev) <= -$signed(HYST)` and `new_sample_in[15]==0`; suppresses noise-induced triggers near zero.
- Undefined: plain sign-change trigger as in Operation; `HYST` unused.

## Structure
- Shared package `wave_pkg`: state encodings (ARMED, ACTIVE, WAIT), `SAMPLE_W=16`, `DISP_W=8`, default `SAMPLES_LOG2`.
- One sub-module `wave_trigger_detect`: combinational, inputs `prev`/`cur`, output `trigger`; contains the `WAVE_CAPTURE_HYST_EN` conditional.
- FSM, index counter, `prev` register and output registers stay in `wave_capture`.

## Test plan
- Reset then samples 16'h1000, 16'hF000, 16'h0100 -> no write for first two; third triggers, `write_enable` next cycle, `write_address=9'h100`, `write_sample=8'h81`.
- After trigger, 255 strobes of 16'h7F00 -> addresses 9'h101..9'h1FF, `write_sample=8'hFF`, then WAIT; extra strobes produce no writes.
- In WAIT hold `wave_display_idle=0` 50 cycles then 1 -> `read_index` stays 0, goes 1 one cycle after idle; next capture writes 9'h000..9'h0FF.
- Assert `reset` at index 100 in ACTIVE -> next cycle `write_enable=0`, `read_index=0`, state ARMED; 16'h8000 then 16'h0000 retriggers at address 9'h100.
- Back-to-back strobes every cycle for 256 samples after trigger -> 256 consecutive `write_enable` cycles, no gaps, no duplicate addresses.
- With `WAVE_CAPTURE_HYST_EN`, HYST=256: 16'hFFF0 -> 16'h0010 no trigger; 16'hFE00 -> 16'h0010 triggers.
